// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite attribute type, geometry constants and tile ROM image
package sprite_pkg;
    localparam int NUM_SPR = 4;
    localparam int SPR_W = 4;
    localparam int SPR_H = 4;
    localparam int NUM_TILES = 8;
    localparam int FRAME_W = 24;
    localparam int FRAME_H = 45;
    localparam logic [4:0] TRANSP_CODE = 5'h15;
    localparam int IDX_W = $clog2(NUM_SPR);
    localparam int TILE_W = $clog2(NUM_TILES);
    localparam int ROM_DEPTH = NUM_TILES * SPR_W * SPR_H;
    localparam int ROM_AW = $clog2(ROM_DEPTH);

    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [TILE_W-1:0] tile;
        logic              vis;
    } spr_attr_t;

    // Tile image contents; some entries land on TRANSP_CODE to give sprites see-through pixels
    function automatic logic [4:0] tileRomWord(input int addr);
        return 5'((addr * 5 + 3) % 32);
    endfunction
endpackage

// File: rtl/sprite_tile_rom.sv
// sprite_tile_rom: synchronous single-port tile ROM, NUM_TILES*SPR_W*SPR_H x 5 bits
module sprite_tile_rom
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [4:0]        data
);
    // Registered read gives the one-cycle ROM stage of the pipeline
    always_ff @(posedge Clk) begin
        data <= tileRomWord(int'(addr));
    end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: overlays prioritised sprites onto the frame, emitting TRANSP_CODE where uncovered
module sprite_compositor
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              VS,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [TILE_W-1:0] wr_tile,
    input  logic              wr_vis,
    output logic [4:0]        pixelIn,
    output logic              commit_pulse
);
    spr_attr_t         shadowSet [NUM_SPR];
    spr_attr_t         activeSet [NUM_SPR];
    logic              vsD;
    logic              vsFall;
    logic              hitValid;
    logic [ROM_AW-1:0] hitAddr;
    logic              selValid;
    logic              inFrame;
    logic [ROM_AW-1:0] romAddr;
    logic              pixValid;
    logic [4:0]        romData;

    assign vsFall = !VS && vsD;

    // Shadow writes land any time; the active set copies the pre-edge shadow on VS falling edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int s = 0; s < NUM_SPR; s++) begin
                shadowSet[s] <= '0;
                activeSet[s] <= '0;
            end
            vsD <= 1'b1;
            commit_pulse <= 1'b0;
        end else begin
            vsD <= VS;
            commit_pulse <= vsFall;
            if (vsFall) activeSet <= shadowSet;
            if (wr_en && int'(wr_idx) < NUM_SPR)
                shadowSet[wr_idx] <= '{x: wr_x, y: wr_y, tile: wr_tile, vis: wr_vis};
        end
    end

    // Hit detection at 11 bits so x+SPR_W cannot wrap; scanning downward lets the lowest index win
    always_comb begin
        hitValid = 1'b0;
        hitAddr = '0;
        for (int s = NUM_SPR - 1; s >= 0; s--) begin
            if (activeSet[s].vis
                && {1'b0, DrawX} >= {1'b0, activeSet[s].x}
                && {1'b0, DrawX} < {1'b0, activeSet[s].x} + 11'(SPR_W)
                && {1'b0, DrawY} >= {1'b0, activeSet[s].y}
                && {1'b0, DrawY} < {1'b0, activeSet[s].y} + 11'(SPR_H)) begin
                hitValid = 1'b1;
                hitAddr = ROM_AW'(int'(activeSet[s].tile) * SPR_W * SPR_H
                        + int'(DrawY - activeSet[s].y) * SPR_W
                        + int'(DrawX - activeSet[s].x));
            end
        end
    end

    // Stage 1 registers the winner and frame clip; stage 2 aligns the valid flag with ROM data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            selValid <= 1'b0;
            inFrame <= 1'b0;
            romAddr <= '0;
            pixValid <= 1'b0;
        end else begin
            selValid <= hitValid;
            inFrame <= DrawX < 10'(FRAME_W) && DrawY < 10'(FRAME_H);
            romAddr <= hitAddr;
            pixValid <= selValid && inFrame;
        end
    end

    sprite_tile_rom tileRom (
        .Clk  (Clk),
        .addr (romAddr),
        .data (romData)
    );

    assign pixelIn = pixValid ? romData : TRANSP_CODE;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed scoreboard bench for the sprite compositor
module tb_sprite_compositor;
    import sprite_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              VS;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [9:0]        wr_x;
    logic [9:0]        wr_y;
    logic [TILE_W-1:0] wr_tile;
    logic              wr_vis;
    logic [4:0]        pixelIn;
    logic              commit_pulse;

    int testsRun = 0;
    int failCount = 0;
    int shX [NUM_SPR], shY [NUM_SPR], shT [NUM_SPR], shV [NUM_SPR];
    int acX [NUM_SPR], acY [NUM_SPR], acT [NUM_SPR], acV [NUM_SPR];
    logic mVsD = 1'b1;
    logic [4:0] expQ [$];

    sprite_compositor dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .VS           (VS),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_tile      (wr_tile),
        .wr_vis       (wr_vis),
        .pixelIn      (pixelIn),
        .commit_pulse (commit_pulse)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] romModel(input int a);
        return 5'((5 * a + 3) & 31);
    endfunction

    function automatic logic [4:0] pixModel(input int x, input int y);
        if (x >= FRAME_W || y >= FRAME_H) return TRANSP_CODE;
        for (int s = 0; s < NUM_SPR; s++)
            if (acV[s] != 0 && x >= acX[s] && x < acX[s] + SPR_W && y >= acY[s] && y < acY[s] + SPR_H)
                return romModel(acT[s] * SPR_W * SPR_H + (y - acY[s]) * SPR_W + (x - acX[s]));
        return TRANSP_CODE;
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        testsRun++;
        assert (got === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int x, input int y);
        logic [4:0] e;
        logic fall;
        e = pixModel(x, y);
        fall = !Reset && !VS && mVsD;
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge Clk);
        if (Reset) begin
            for (int s = 0; s < NUM_SPR; s++) begin
                shX[s] = 0; shY[s] = 0; shT[s] = 0; shV[s] = 0;
                acX[s] = 0; acY[s] = 0; acT[s] = 0; acV[s] = 0;
            end
            mVsD = 1'b1;
        end else begin
            if (fall) begin
                acX = shX; acY = shY; acT = shT; acV = shV;
            end
            if (wr_en) begin
                shX[wr_idx] = int'(wr_x);
                shY[wr_idx] = int'(wr_y);
                shT[wr_idx] = int'(wr_tile);
                shV[wr_idx] = int'(wr_vis);
            end
            mVsD = VS;
        end
        #1;
        if (Reset) begin
            check("reset_pix", pixelIn, TRANSP_CODE);
            check("reset_commit", {4'b0, commit_pulse}, 5'd0);
            expQ.delete();
            expQ.push_back(TRANSP_CODE);
        end else begin
            check("commit_pulse", {4'b0, commit_pulse}, {4'b0, fall});
            expQ.push_back(e);
            if (expQ.size() >= 2) check("pix", pixelIn, expQ.pop_front());
        end
    endtask

    task automatic writeSlot(input int idx, input int x, input int y, input int t, input int v);
        wr_idx = IDX_W'(idx);
        wr_x = 10'(x);
        wr_y = 10'(y);
        wr_tile = TILE_W'(t);
        wr_vis = v[0];
        wr_en = 1'b1;
        step(0, 0);
        wr_en = 1'b0;
    endtask

    task automatic commitFrame();
        VS = 1'b0;
        step(0, 0);
        step(0, 0);
        VS = 1'b1;
        step(0, 0);
    endtask

    initial begin
        Reset = 1'b1; VS = 1'b1; wr_en = 1'b0; wr_idx = '0;
        wr_x = '0; wr_y = '0; wr_tile = '0; wr_vis = 1'b0;
        DrawX = '0; DrawY = '0;
        step(0, 0);
        Reset = 1'b0;
        // Empty sprite set: whole frame transparent, no commits
        for (int y = 0; y < FRAME_H; y++)
            for (int x = 0; x < FRAME_W; x++) step(x, y);
        // Single sprite, commit on VS fall, VS held low gives no second commit
        writeSlot(0, 2, 3, 1, 1);
        VS = 1'b0;
        step(2, 3);
        step(2, 3);
        step(6, 3);
        step(3, 4);
        VS = 1'b1;
        step(2, 3);
        step(5, 6);
        step(6, 3);
        // Priority between overlapping slots, then lower slot hidden
        writeSlot(0, 3, 3, 0, 1);
        writeSlot(1, 4, 4, 2, 1);
        commitFrame();
        step(5, 5);
        step(4, 4);
        step(7, 7);
        writeSlot(0, 3, 3, 0, 0);
        commitFrame();
        step(5, 5);
        step(4, 4);
        // Shadow writes invisible until commit; coincident write misses that commit
        writeSlot(0, 2, 3, 1, 1);
        commitFrame();
        writeSlot(0, 10, 3, 1, 1);
        step(2, 3);
        step(10, 3);
        wr_idx = '0; wr_x = 10'd14; wr_y = 10'd3; wr_tile = TILE_W'(1); wr_vis = 1'b1;
        wr_en = 1'b1;
        VS = 1'b0;
        step(10, 3);
        wr_en = 1'b0;
        step(10, 3);
        step(14, 3);
        step(2, 3);
        VS = 1'b1;
        step(11, 4);
        commitFrame();
        step(14, 3);
        step(10, 3);
        step(15, 4);
        // Sprite clipped at the bottom-right frame corner
        writeSlot(0, 0, 0, 0, 0);
        writeSlot(1, 0, 0, 0, 0);
        writeSlot(2, 22, 43, 3, 1);
        commitFrame();
        for (int y = 41; y <= 46; y++)
            for (int x = 20; x <= 25; x++) step(x, y);
        // Reset while a sprite is showing clears it until rewritten
        step(22, 43);
        Reset = 1'b1;
        step(23, 44);
        Reset = 1'b0;
        step(22, 43);
        step(23, 44);
        step(22, 44);
        commitFrame();
        step(22, 43);
        writeSlot(2, 22, 43, 3, 1);
        commitFrame();
        step(22, 43);
        step(23, 44);
        step(0, 0);
        step(0, 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
